// File: rtl/sysid_ctrl_pkg.sv
// rtl/sysid_ctrl_pkg.sv - shared states and constants for the system-ID boot checker
package sysid_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_LAT_ID,
        ST_RD_TS,
        ST_LAT_TS,
        ST_CMP,
        ST_DONE,
        ST_FAIL
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   SYSID_TO_W    = 8;

    function automatic logic sysid_is_rd(sysid_state_t s);
        return (s == ST_RD_ID) || (s == ST_RD_TS);
    endfunction

    function automatic logic sysid_is_busy(sysid_state_t s);
        return (s == ST_RD_ID) || (s == ST_LAT_ID) || (s == ST_RD_TS) ||
               (s == ST_LAT_TS) || (s == ST_CMP);
    endfunction

endpackage

// File: rtl/sysid_rd_port.sv
// rtl/sysid_rd_port.sv - single Avalon-MM read: accept detect, latency pipe, stall timeout
module sysid_rd_port
    import sysid_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_active,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        accept,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_timeout
);

    localparam logic [SYSID_TO_W-1:0] TIMEOUT_C = SYSID_TO_W'(TIMEOUT);
    localparam logic [SYSID_TO_W-1:0] ONE_C     = SYSID_TO_W'(1);

    logic [SYSID_TO_W-1:0] to_cnt_q, to_cnt_d;

    assign accept     = rd_active & ~avm_waitrequest;
    assign rd_timeout = rd_active & avm_waitrequest & ((to_cnt_q + ONE_C) == TIMEOUT_C);
    assign rd_data    = avm_readdata;

    // Counter restarts whenever no read is pending, so each new read begins from zero.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!rd_active || accept) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + ONE_C;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_no_lat
            assign rd_valid = accept;
        end else begin : g_lat
            logic [READ_LATENCY-1:0] pipe_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= (pipe_q << 1) | READ_LATENCY'(accept);
                end
            end
            assign rd_valid = pipe_q[READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - boot-time ID/timestamp checker gating crypt_enable; option SYSID_BOOT_CHECKER_RECHECK_EN
module sysid_boot_checker
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1461113250,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT        = 16,
    parameter logic [23:0] RECHECK_PERIOD = 24'd10_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        error,
    output logic        crypt_enable,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    sysid_state_t state_q, state_d;
    logic        read_q, read_d, addr_q, addr_d, busy_q, busy_d;
    logic        done_q, done_d, idm_q, idm_d, tsm_q, tsm_d;
    logic        err_q, err_d, crypt_q, crypt_d;
    logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
    logic [31:0] id_buf_q, id_buf_d, ts_buf_q, ts_buf_d;
    logic        accept, rd_valid, rd_timeout, recheck;
    logic [31:0] rd_data;

    sysid_rd_port #(
        .READ_LATENCY(READ_LATENCY),
        .TIMEOUT     (TIMEOUT)
    ) u_rd_port (
        .clock          (clock),
        .reset          (reset),
        .rd_active      (read_q),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .accept         (accept),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_timeout     (rd_timeout)
    );

`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
    logic [23:0] rc_cnt_q;
    always_ff @(posedge clock) begin
        if (reset || state_q != ST_DONE) begin
            rc_cnt_q <= '0;
        end else begin
            rc_cnt_q <= rc_cnt_q + 24'd1;
        end
    end
    assign recheck = (state_q == ST_DONE) && (rc_cnt_q == RECHECK_PERIOD - 24'd1);
`else
    logic unused_recheck_period;
    assign unused_recheck_period = ^RECHECK_PERIOD;
    assign recheck = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_RD_ID;
            ST_RD_ID: begin
                if (rd_timeout)  state_d = ST_FAIL;
                else if (accept) state_d = (READ_LATENCY == 0) ? ST_RD_TS : ST_LAT_ID;
            end
            ST_LAT_ID: if (rd_valid) state_d = ST_RD_TS;
            ST_RD_TS: begin
                if (rd_timeout)  state_d = ST_FAIL;
                else if (accept) state_d = (READ_LATENCY == 0) ? ST_CMP : ST_LAT_TS;
            end
            ST_LAT_TS: if (rd_valid) state_d = ST_CMP;
            ST_CMP:    state_d = ST_DONE;
            ST_DONE:   if (start || recheck) state_d = ST_RD_ID;
            ST_FAIL:   if (start) state_d = ST_RD_ID;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Words are staged and only published at CMP, so a timed-out check leaves captured_* intact.
    always_comb begin
        id_buf_d = id_buf_q;
        ts_buf_d = ts_buf_q;
        done_d   = done_q;
        idm_d    = idm_q;
        tsm_d    = tsm_q;
        err_d    = err_q;
        crypt_d  = crypt_q;
        cap_id_d = cap_id_q;
        cap_ts_d = cap_ts_q;
        read_d   = sysid_is_rd(state_d);
        addr_d   = (state_d == ST_RD_TS || state_d == ST_LAT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d   = sysid_is_busy(state_d);

        if (rd_valid && (state_q == ST_RD_ID || state_q == ST_LAT_ID)) id_buf_d = rd_data;
        if (rd_valid && (state_q == ST_RD_TS || state_q == ST_LAT_TS)) ts_buf_d = rd_data;

        if (state_q == ST_CMP) begin
            idm_d    = (id_buf_q == EXPECTED_ID);
            tsm_d    = (ts_buf_q == EXPECTED_TS);
            done_d   = 1'b1;
            err_d    = 1'b0;
            crypt_d  = idm_d & tsm_d;
            cap_id_d = id_buf_q;
            cap_ts_d = ts_buf_q;
        end else if (state_d == ST_FAIL && state_q != ST_FAIL) begin
            done_d  = 1'b0;
            err_d   = 1'b1;
            crypt_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            read_q   <= 1'b0;
            addr_q   <= SYSID_ADDR_ID;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idm_q    <= 1'b0;
            tsm_q    <= 1'b0;
            err_q    <= 1'b0;
            crypt_q  <= 1'b0;
            cap_id_q <= '0;
            cap_ts_q <= '0;
            id_buf_q <= '0;
            ts_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            idm_q    <= idm_d;
            tsm_q    <= tsm_d;
            err_q    <= err_d;
            crypt_q  <= crypt_d;
            cap_id_q <= cap_id_d;
            cap_ts_q <= cap_ts_d;
            id_buf_q <= id_buf_d;
            ts_buf_q <= ts_buf_d;
        end
    end

    assign avm_read     = read_q;
    assign avm_address  = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign id_match     = idm_q;
    assign ts_match     = tsm_q;
    assign error        = err_q;
    assign crypt_enable = crypt_q;
    assign captured_id  = cap_id_q;
    assign captured_ts  = cap_ts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb/tb_sysid_boot_checker.sv - directed checks of sysid_boot_checker at latency 0 and latency 2
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_TS = 32'd1461113250;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst0, start0, addr0, read0, wait0, busy0, done0, idm0, tsm0, err0, crypt0;
    logic [31:0] id0, ts0, rdata0, cap_id0, cap_ts0;
    logic        rst2, start2, addr2, read2, wait2, busy2, done2, idm2, tsm2, err2, crypt2;
    logic [31:0] id2, ts2, rdata2, cap_id2, cap_ts2;

    assign rdata0 = addr0 ? ts0 : id0;

    // Latency-2 slave: returns the word two cycles after accept, garbage otherwise; ID reads stall 3 cycles.
    logic acc1_v = 1'b0, acc1_a = 1'b0, acc2_v = 1'b0, acc2_a = 1'b0;
    int   stall_cnt = 0;
    assign wait2  = read2 && !addr2 && (stall_cnt < 3);
    assign rdata2 = acc2_v ? (acc2_a ? ts2 : id2) : 32'hDEADBEEF;
    always @(posedge clock) begin
        acc1_v    <= read2 & ~wait2;
        acc1_a    <= addr2;
        acc2_v    <= acc1_v;
        acc2_a    <= acc1_a;
        stall_cnt <= read2 ? stall_cnt + (wait2 ? 1 : 0) : 0;
    end

    sysid_boot_checker #(.READ_LATENCY(0), .TIMEOUT(16)) u_dut0 (
        .clock(clock), .reset(rst0), .start(start0),
        .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0), .avm_readdata(rdata0),
        .busy(busy0), .done(done0), .id_match(idm0), .ts_match(tsm0), .error(err0),
        .crypt_enable(crypt0), .captured_id(cap_id0), .captured_ts(cap_ts0)
    );

    sysid_boot_checker #(.READ_LATENCY(2), .TIMEOUT(16), .RECHECK_PERIOD(24'd100)) u_dut2 (
        .clock(clock), .reset(rst2), .start(start2),
        .avm_address(addr2), .avm_read(read2), .avm_waitrequest(wait2), .avm_readdata(rdata2),
        .busy(busy2), .done(done2), .id_match(idm2), .ts_match(tsm2), .error(err2),
        .crypt_enable(crypt2), .captured_id(cap_id2), .captured_ts(cap_ts2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0; wait0 = 1'b0;
        id0 = 32'd0; ts0 = EXP_TS; id2 = 32'd0; ts2 = EXP_TS;
        tick(); tick();
        chk("rst_read", read0, 0);   chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);   chk("rst_crypt", crypt0, 0);
        chk("rst_err", err0, 0);     chk("rst_cap_ts", cap_ts0, 0);

        // boot check, latency 0, good slave
        rst0 = 1'b0;
        chk("e0_read", read0, 0);
        tick();
        chk("e1_read", read0, 1); chk("e1_addr", addr0, 0); chk("e1_busy", busy0, 1);
        tick();
        chk("e2_read", read0, 1); chk("e2_addr", addr0, 1);
        tick();
        chk("e3_done", done0, 0); chk("e3_busy", busy0, 1);
        tick();
        chk("e4_done", done0, 1); chk("e4_idm", idm0, 1); chk("e4_tsm", tsm0, 1);
        chk("e4_crypt", crypt0, 1); chk("e4_busy", busy0, 0); chk("e4_cap_ts", cap_ts0, EXP_TS);

        // timestamp off by one
        ts0 = EXP_TS + 32'd1;
        start0 = 1'b1; tick(); start0 = 1'b0; tick(); tick(); tick();
        chk("badts_tsm", tsm0, 0); chk("badts_idm", idm0, 1); chk("badts_crypt", crypt0, 0);
        chk("badts_done", done0, 1); chk("badts_cap_ts", cap_ts0, EXP_TS + 32'd1);

        // waitrequest stuck: timeout after 16 stalled cycles
        wait0 = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        repeat (15) tick();
        chk("to_read_s16", read0, 1);
        tick();
        chk("to_read_s17", read0, 0); chk("to_err", err0, 1); chk("to_crypt", crypt0, 0);
        chk("to_done", done0, 0); chk("to_busy", busy0, 0); chk("to_cap_ts", cap_ts0, EXP_TS + 32'd1);
        tick(); tick(); tick();
        wait0 = 1'b0;
        chk("to_read_idle", read0, 0);
        ts0 = EXP_TS;
        start0 = 1'b1; tick(); start0 = 1'b0; tick(); tick(); tick();
        chk("rec_done", done0, 1); chk("rec_err", err0, 0); chk("rec_crypt", crypt0, 1);

        // latency 2 with 3 stall cycles on the ID read: DONE 11 cycles after E0
        rst2 = 1'b0;
        repeat (4) tick();
        chk("l2_acc_read", read2, 1); chk("l2_acc_addr", addr2, 0);
        tick();
        chk("l2_lat_read", read2, 0); chk("l2_lat_busy", busy2, 1);
        repeat (5) tick();
        chk("l2_e10_done", done2, 0); chk("l2_e10_busy", busy2, 1);
        tick();
        chk("l2_e11_done", done2, 1); chk("l2_idm", idm2, 1); chk("l2_tsm", tsm2, 1);
        chk("l2_crypt", crypt2, 1); chk("l2_cap_ts", cap_ts2, EXP_TS); chk("l2_cap_id", cap_id2, 0);

        // start while busy is dropped
        start2 = 1'b1; tick(); start2 = 1'b0; tick();
        start2 = 1'b1; tick(); start2 = 1'b0;
        repeat (8) tick();
        chk("sb_done", done2, 1); chk("sb_busy11", busy2, 0);
        tick();
        chk("sb_busy12", busy2, 0);

        // reset while in LAT_TS
        start2 = 1'b1; tick(); start2 = 1'b0;
        repeat (7) tick();
        chk("lt_busy", busy2, 1); chk("lt_read", read2, 0); chk("lt_addr", addr2, 1);
        rst2 = 1'b1; tick();
        chk("lt_rst_busy", busy2, 0); chk("lt_rst_done", done2, 0); chk("lt_rst_crypt", crypt2, 0);
        chk("lt_rst_idm", idm2, 0); chk("lt_rst_cap_ts", cap_ts2, 0); chk("lt_rst_read", read2, 0);
        rst2 = 1'b0;
        repeat (11) tick();
        chk("lt_auto_done", done2, 1); chk("lt_auto_crypt", crypt2, 1);

        // ID changes after a passing check
        id2 = 32'd5;
        repeat (99) tick();
        chk("rc_d99_busy", busy2, 0); chk("rc_d99_crypt", crypt2, 1);
        tick();
`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
        chk("rc_d100_busy", busy2, 1);
        repeat (9) tick();
        chk("rc_cmp_crypt", crypt2, 1);
        tick();
        chk("rc_end_crypt", crypt2, 0); chk("rc_end_idm", idm2, 0);
        chk("rc_end_done", done2, 1); chk("rc_end_cap_id", cap_id2, 5);
`else
        chk("rc_d100_busy", busy2, 0);
        repeat (10) tick();
        chk("rc_end_crypt", crypt2, 1); chk("rc_end_cap_id", cap_id2, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Boot-time sequencer for the system-ID Avalon-MM slave. After reset (or on request), it reads the ID word (address 0) and the timestamp word (address 1). It compares both against expected values and gates the video encryption datapath through `crypt_enable`. It sits between the Qsys interconnect (as a single-master Avalon-MM read port) and the encryption core's enable input.

## Interface
Parameters:
- `EXPECTED_ID`, 32'd0: required value at address 0.
- `EXPECTED_TS`, 32'd1461113250: required value at address 1.
- `READ_LATENCY`, 0: slave read latency in cycles after the accept cycle; legal range 0..3.
- `TIMEOUT`, 16: maximum cycles `avm_waitrequest` may hold off a single read; legal range 1..255.
- `RECHECK_PERIOD`, 24'd10_000_000: cycles between automatic re-checks; used only with the macro below.

Ports:
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that launches a check. Ignored while `busy`.
- `avm_address` out 1: 0 selects the ID word, 1 selects the timestamp word.
- `avm_read` out 1: read strobe. Held until accepted.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: read data.
- `busy` out 1: a check is in progress.
- `done` out 1: last check completed with both words read.
- `id_match` out 1: captured ID equals `EXPECTED_ID`.
- `ts_match` out 1: captured timestamp equals `EXPECTED_TS`.
- `error` out 1: last check aborted by timeout.
- `crypt_enable` out 1: encryption datapath permitted.
- `captured_id` out 32: last ID read.
- `captured_ts` out 32: last timestamp read.

## Operation
- States:
  - IDLE
  - RD_ID: `avm_read=1`, `avm_address=0`
  - LAT_ID: waiting for readdata
  - RD_TS: `avm_read=1`, `avm_address=1`
  - LAT_TS: waiting for readdata
  - CMP
  - DONE
  - FAIL
- IDLE → RD_ID: automatic on the first cycle after reset deasserts; no `start` is required.
- DONE/FAIL → RD_ID: on `start`.
- A read is accepted in a cycle where `avm_read=1` and `avm_waitrequest=0`.
- Data is captured exactly `READ_LATENCY` cycles after the accept cycle (the accept cycle itself when `READ_LATENCY=0`).
- LAT states are skipped when `READ_LATENCY=0`.
- Timeout counter:
  - 8-bit; cleared on entry to each RD state; increments on each cycle with waitrequest high.
  - When it reaches `TIMEOUT`, go to FAIL: deassert `avm_read` that edge, set `error=1`, keep `captured_*` from the prior check.
- CMP lasts one cycle:
  - Sets `id_match`/`ts_match` from 32-bit equality.
  - Sets `done=1` and `error=0`.
  - Sets `crypt_enable` to `id_match & ts_match`.
  - Goes to DONE.
- FAIL forces `crypt_enable=0`, `done=0`.
- `busy` is 1 in the RD, LAT and CMP states.
- `done`, `error`, the match flags and `captured_*` hold until the next CMP or FAIL.
- `start` while `busy`: dropped and not queued.
- `start` in the same cycle as `reset`: reset wins.
- Reset mid-read: `avm_read` is low from the next edge; any outstanding latency data is discarded.
- Reset values: `avm_read=0`, `avm_address=0`, `busy=0`, `done=0`, `id_match=0`, `ts_match=0`, `error=0`, `crypt_enable=0`, `captured_id=0`, `captured_ts=0`.

## Timing
- Reset released at edge E0 (first cycle without reset).
  - Cycle E0: IDLE.
  - Cycle E0+1: RD_ID.
  - With `READ_LATENCY=0` and no wait, RD_TS at E0+2, CMP at E0+3.
  - `done` and `crypt_enable` are visible from E0+4.
- General check length, from RD_ID entry to DONE: 2·(1 + W + `READ_LATENCY`) + 1 cycles, where W is the waitrequest stall cycles per read.
- `avm_address` is stable for the whole time `avm_read` is high.
- All outputs are registered.

## Configuration
- Macro: `SYSID_BOOT_CHECKER_RECHECK_EN`.
- With the macro defined:
  - A 24-bit counter runs in DONE. At `RECHECK_PERIOD`, the block re-enters RD_ID as if `start` had been pulsed; the counter clears on leaving DONE.
  - During the re-check, `crypt_enable` keeps its previous value. It drops only if the re-check ends in mismatch or FAIL.
- Without the macro: no counter is built, `RECHECK_PERIOD` is unused, and checks run only after reset or on `start`.

## Structure
- Package `sysid_ctrl_pkg` contains:
  - State enum `sysid_state_t`.
  - Constants `SYSID_ADDR_ID=1'b0` and `SYSID_ADDR_TS=1'b1`.
  - Timeout counter width constant: 8.
- One sub-module, `sysid_rd_port`, handles one Avalon read:
  - Request/accept logic.
  - `READ_LATENCY` shift pipe.
  - Timeout counter.
  - Outputs `rd_valid` with data, or `rd_timeout`.
- The top level holds the FSM, the compare logic and the optional re-check counter.

## Test plan
- Reset release, slave returns 0 / 1461113250, latency 0, no wait → `done=1`, `id_match=1`, `ts_match=1`, `crypt_enable=1` at E0+4.
- Slave returns timestamp 1461113251 → `ts_match=0`, `crypt_enable=0`, `done=1`, `captured_ts=1461113251`.
- Waitrequest held high 20 cycles with `TIMEOUT=16` → `avm_read` drops after 16 stalled cycles, `error=1`, `crypt_enable=0`; a subsequent `start` with a good slave passes.
- `READ_LATENCY=2`, waitrequest 3 cycles on the ID read → data sampled 2 cycles after accept; DONE reached at the formula's cycle count.
- `start` pulsed while `busy`, and `reset` asserted while in LAT_TS → `start` ignored; after reset, all outputs are at reset values and the auto-check restarts.
- With `SYSID_BOOT_CHECKER_RECHECK_EN` and `RECHECK_PERIOD=100`, slave ID changed to 5 after the first pass → re-check launches 100 cycles after DONE; `crypt_enable` stays 1 until that CMP, then goes to 0.
